// File: rtl/branch_pc_unit.sv
// KGP_RISC program-counter / branch-resolution stage: latches ALU flags,
// resolves branches and produces pc, taken, link and illegal-op pulses.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        halt,
  input  logic [3:0]  br_op,
  input  logic [31:0] offset,
  input  logic [31:0] rs_val,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        flag_we,
  output logic [31:0] pc,
  output logic        taken,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        carry_q,
  output logic        zero_q,
  output logic        sign_q,
  output logic        halted,
  output logic        illegal_op
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state, state_n;
  logic [31:0] pc_seq, rel_sum, br_target, pc_n, link_addr_n;
  logic        taken_n, link_we_n, illegal_n;
  logic        carry_n, zero_n, sign_n;
  logic        eff_c, eff_z, eff_s;
  logic        br_taken, op_legal, advance;

  always_comb begin
    pc_seq    = pc + STEP;
    rel_sum   = pc_seq + offset;
    eff_c     = flag_we ? alu_carry : carry_q;
    eff_z     = flag_we ? alu_zero  : zero_q;
    eff_s     = flag_we ? alu_sign  : sign_q;
    br_taken  = 1'b0;
    op_legal  = 1'b1;
    br_target = {rel_sum[31:2], 2'b00};
    unique case (br_op)
      4'd0:       br_taken = 1'b0;
      4'd1, 4'd2: br_taken = 1'b1;
      4'd3: begin
        br_taken  = 1'b1;
        br_target = {rs_val[31:2], 2'b00};
      end
      4'd4:       br_taken = eff_s;
      4'd5:       br_taken = eff_z;
      4'd6:       br_taken = ~eff_z;
      4'd7:       br_taken = eff_c;
      4'd8:       br_taken = ~eff_c;
      default:    op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    link_addr_n = link_addr;
    carry_n     = carry_q;
    zero_n      = zero_q;
    sign_n      = sign_q;
    taken_n     = 1'b0;
    link_we_n   = 1'b0;
    illegal_n   = 1'b0;
    advance     = (state == RUN) && instr_valid && !stall;
    // halt is honoured even while stalled; it also suppresses any branch effect
    if ((state == RUN) && instr_valid && halt) state_n = HALT;
    if (advance) begin
      if (flag_we) begin
        carry_n = alu_carry;
        zero_n  = alu_zero;
        sign_n  = alu_sign;
      end
      if (!halt) begin
        pc_n      = br_taken ? br_target : pc_seq;
        taken_n   = br_taken;
        link_we_n = (br_op == 4'd2);
        illegal_n = !op_legal;
        if (br_op == 4'd2) link_addr_n = pc_seq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      link_addr  <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      sign_q     <= 1'b0;
      taken      <= 1'b0;
      link_we    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      link_addr  <= link_addr_n;
      carry_q    <= carry_n;
      zero_q     <= zero_n;
      sign_q     <= sign_n;
      taken      <= taken_n;
      link_we    <= link_we_n;
      illegal_op <= illegal_n;
    end
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed vector table, halt/reset sequences,
// then randomized traffic against an arithmetic reference model.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, stall, halt, flag_we;
  logic [3:0]  br_op;
  logic [31:0] offset, rs_val;
  logic        alu_carry, alu_zero, alu_sign;
  logic [31:0] pc, link_addr;
  logic        taken, link_we, carry_q, zero_q, sign_q, halted, illegal_op;

  int checks   = 0;
  int failures = 0;

  branch_pc_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .stall(stall), .halt(halt),
    .br_op(br_op), .offset(offset), .rs_val(rs_val), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .flag_we(flag_we), .pc(pc),
    .taken(taken), .link_we(link_we), .link_addr(link_addr), .carry_q(carry_q),
    .zero_q(zero_q), .sign_q(sign_q), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, st, h;
    logic [3:0] op;
    logic [31:0] off, rs;
    logic c, z, s, fwe;
    logic [31:0] e_pc;
    logic e_tk, e_lw;
    logic [31:0] e_la;
    logic e_c, e_z, e_s, e_il, e_hl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic st, logic h, logic [3:0] op,
                              logic [31:0] off, logic [31:0] rs, logic c, logic z,
                              logic s, logic fwe, logic [31:0] e_pc, logic e_tk,
                              logic e_lw, logic [31:0] e_la, logic e_c, logic e_z,
                              logic e_s, logic e_il, logic e_hl);
    vec_t r;
    r.v = v; r.st = st; r.h = h; r.op = op; r.off = off; r.rs = rs;
    r.c = c; r.z = z; r.s = s; r.fwe = fwe;
    r.e_pc = e_pc; r.e_tk = e_tk; r.e_lw = e_lw; r.e_la = e_la;
    r.e_c = e_c; r.e_z = e_z; r.e_s = e_s; r.e_il = e_il; r.e_hl = e_hl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic e_tk,
                            input logic e_lw, input logic [31:0] e_la, input logic e_c,
                            input logic e_z, input logic e_s, input logic e_il,
                            input logic e_hl);
    chk({tag, ".pc"},         pc,                e_pc);
    chk({tag, ".taken"},      {31'd0, taken},    {31'd0, e_tk});
    chk({tag, ".link_we"},    {31'd0, link_we},  {31'd0, e_lw});
    chk({tag, ".link_addr"},  link_addr,         e_la);
    chk({tag, ".carry_q"},    {31'd0, carry_q},  {31'd0, e_c});
    chk({tag, ".zero_q"},     {31'd0, zero_q},   {31'd0, e_z});
    chk({tag, ".sign_q"},     {31'd0, sign_q},   {31'd0, e_s});
    chk({tag, ".illegal_op"}, {31'd0, illegal_op}, {31'd0, e_il});
    chk({tag, ".halted"},     {31'd0, halted},   {31'd0, e_hl});
  endtask

  task automatic drive(input logic v, input logic st, input logic h, input logic [3:0] op,
                       input logic [31:0] off, input logic [31:0] rs, input logic c,
                       input logic z, input logic s, input logic fwe);
    instr_valid = v; stall = st; halt = h; br_op = op; offset = off; rs_val = rs;
    alu_carry = c; alu_zero = z; alu_sign = s; flag_we = fwe;
  endtask

  // reference model state
  logic [31:0] m_pc, m_la;
  logic m_c, m_z, m_s, m_hl, m_tk, m_lw, m_il;

  task automatic model_reset();
    m_pc = 32'h0; m_la = 32'h0; m_c = 0; m_z = 0; m_s = 0;
    m_hl = 0; m_tk = 0; m_lw = 0; m_il = 0;
  endtask

  task automatic model_step(input logic v, input logic st, input logic h,
                            input int op, input logic [31:0] off, input logic [31:0] rs,
                            input logic c, input logic z, input logic s, input logic fwe);
    longint unsigned seq, rel, tgt;
    logic fc, fz, fs, go;
    m_tk = 0; m_lw = 0; m_il = 0;
    if (m_hl) return;
    fc = fwe ? c : m_c;
    fz = fwe ? z : m_z;
    fs = fwe ? s : m_s;
    if (v && !st) begin
      if (fwe) begin m_c = c; m_z = z; m_s = s; end
      if (!h) begin
        seq = (longint'(m_pc) + 4) % 64'h1_0000_0000;
        rel = (seq + longint'(off)) % 64'h1_0000_0000;
        rel = (rel / 4) * 4;
        tgt = (op == 3) ? (longint'(rs) / 4) * 4 : rel;
        go = (op == 1) || (op == 2) || (op == 3) ||
             (op == 4 && fs) || (op == 5 && fz) || (op == 6 && !fz) ||
             (op == 7 && fc) || (op == 8 && !fc);
        m_pc = go ? 32'(tgt) : 32'(seq);
        m_tk = go;
        m_il = (op > 8);
        if (op == 2) begin m_lw = 1; m_la = 32'(seq); end
      end
    end
    if (v && h) m_hl = 1;
  endtask

  initial begin
    logic v, st, h, fwe, c, z, s;
    logic [3:0] op;
    logic [31:0] off, rs, b;

    // v st h op off rs c z s fwe | pc tk lw la c z s il hl
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h4,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h8,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'hC,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,3,0,32'h40,0,0,0,0, 32'h40,1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,5,32'h10,0,0,1,0,1, 32'h54,1,0,0,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,5,32'h10,0,0,0,0,0, 32'h68,1,0,0,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,3,0,32'h100,0,0,0,0, 32'h100,1,0,0,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,7,32'h40,0,1,0,0,0, 32'h104,0,0,0,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,8,32'hFFFF_FFF8,0,0,0,0,0, 32'h100,1,0,0,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,3,0,32'h23,0,0,0,0, 32'h20,1,0,0,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,2,32'h100,0,0,0,0,0, 32'h124,1,1,32'h24,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,3,0,32'h203,0,0,0,0, 32'h200,1,0,32'h24,0,1,0,0,0));
    tbl.push_back(mk(1,1,0,1,32'h40,0,0,0,0,0, 32'h200,0,0,32'h24,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h40,0,0,0,0,0, 32'h200,0,0,32'h24,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,4,0,0,0,0,1,1, 32'h204,1,0,32'h24,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,12,32'h40,0,0,0,0,0, 32'h208,0,0,32'h24,0,0,1,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h20C,0,0,32'h24,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,3,0,32'hFFFF_FFFC,0,0,0,0, 32'hFFFF_FFFC,1,0,32'h24,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h0,0,0,32'h24,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,3,0,32'hFFFF_FFF0,0,0,0,0, 32'hFFFF_FFF0,1,0,32'h24,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,1,32'h10,0,0,0,0,0, 32'h4,1,0,32'h24,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,6,32'h8,0,0,1,0,0, 32'h10,1,0,32'h24,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,7,32'h20,0,1,0,0,1, 32'h34,1,0,32'h24,1,0,0,0,0));

    rst = 1'b0;
    drive(0,0,0,0,0,0,0,0,0,0);
    #12;
    check_outs("reset", 32'h0,0,0,32'h0,0,0,0,0,0);
    rst = 1'b1;
    #1;
    check_outs("release", 32'h0,0,0,32'h0,0,0,0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].st, tbl[i].h, tbl[i].op, tbl[i].off, tbl[i].rs,
            tbl[i].c, tbl[i].z, tbl[i].s, tbl[i].fwe);
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_tk, tbl[i].e_lw,
                 tbl[i].e_la, tbl[i].e_c, tbl[i].e_z, tbl[i].e_s, tbl[i].e_il,
                 tbl[i].e_hl);
    end

    // halt while stalled, then frozen for 10 cycles
    drive(1,1,1,1,32'h40,0,0,0,0,0);
    @(posedge clk); #1;
    check_outs("halt_enter", 32'h34,0,0,32'h24,1,0,0,0,1);
    for (int k = 0; k < 10; k++) begin
      drive(1,0,0,4'(k % 9),32'h40,32'h80,0,1,1,1);
      @(posedge clk); #1;
      check_outs($sformatf("halt_hold%0d", k), 32'h34,0,0,32'h24,1,0,0,0,1);
    end
    #2 rst = 1'b0;
    #1 check_outs("halt_async_rst", 32'h0,0,0,32'h0,0,0,0,0,0);
    drive(1,0,0,3,0,32'h80,0,0,0,0);
    #1 rst = 1'b1;

    // reset landing in the middle of a taken pulse
    @(posedge clk); #1;
    check_outs("pulse_set", 32'h80,1,0,32'h0,0,0,0,0,0);
    #2 rst = 1'b0;
    #1 check_outs("pulse_async_rst", 32'h0,0,0,32'h0,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0,0,0);
    #1 rst = 1'b1;
    model_reset();

    for (int n = 0; n < 2000; n++) begin
      v   = ($urandom % 8) != 0;
      st  = ($urandom % 6) == 0;
      h   = ($urandom % 97) == 0;
      op  = 4'($urandom % 16);
      b   = $urandom;
      off = ($urandom % 4 == 0) ? $urandom : {{22{b[9]}}, b[9:0]};
      rs  = $urandom;
      c = 1'($urandom); z = 1'($urandom); s = 1'($urandom);
      fwe = h ? 1'b0 : 1'($urandom);
      drive(v, st, h, op, off, rs, c, z, s, fwe);
      if (($urandom % 150) == 0 || (m_hl && ($urandom % 15) == 0)) begin
        rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
      end
      model_step(v, st, h, int'(op), off, rs, c, z, s, fwe);
      @(posedge clk); #1;
      check_outs($sformatf("rnd%0d", n), m_pc, m_tk, m_lw, m_la, m_c, m_z, m_s,
                 m_il, m_hl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage for KGP_RISC, directly downstream of the ALU. Each cycle it latches the ALU's carry/zero/sign flags and resolves the current instruction's branch against them. It then advances the PC by one instruction or redirects it to a branch target. It also emits the link write for `bl` and a one-cycle `taken` pulse the front end uses to flush the wrong-path fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, byte increment for sequential flow

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  current instruction valid and executing this cycle
- stall  in  1  hold PC and all state (except reset and halt)
- halt  in  1  halt instruction in execute
- br_op  in  4  0 none, 1 b, 2 bl, 3 br, 4 bltz, 5 bz, 6 bnz, 7 bcy, 8 bncy; 9-15 illegal
- offset  in  32  sign-extended byte offset for PC-relative branches
- rs_val  in  32  register value, used as target for `br`
- alu_carry, alu_zero, alu_sign  in  1 each  flags from the ALU this cycle
- flag_we  in  1  the ALU flags belong to the current instruction and must be latched
- pc  out  32  current program counter, registered
- taken  out  1  registered one-cycle pulse: a branch redirected pc
- link_we  out  1  registered one-cycle pulse: write link_addr to r31
- link_addr  out  32  registered return address (old pc + PC_STEP)
- carry_q, zero_q, sign_q  out  1 each  architectural flag register
- halted  out  1  unit is in HALT
- illegal_op  out  1  registered one-cycle pulse for br_op 9-15

## Operation
- FSM states: RUN, HALT. Reset enters RUN. In RUN, `halt & instr_valid` goes to HALT at the next edge, even when stall=1. HALT is left only by reset. In HALT the pc and flags are frozen and all pulse outputs stay 0.
- An instruction advances when state=RUN, instr_valid=1 and stall=0. Otherwise the unit holds pc and flags and drives all pulse outputs 0 at the next edge.
- Flag latch: on advance with flag_we=1, carry_q/zero_q/sign_q load alu_carry/alu_zero/alu_sign.
- Effective flags for the branch decision: the incoming ALU flags when flag_we=1 in the same cycle (bypass); otherwise the *_q values.
- Conditions:
  - b, bl, br: always taken
  - bltz: taken when sign=1
  - bz: taken when zero=1
  - bnz: taken when zero=0
  - bcy: taken when carry=1
  - bncy: taken when carry=0
- Targets:
  - b, bl and conditional branches: pc + PC_STEP + offset, modulo 2^32, with bits [1:0] forced to 0.
  - br: rs_val with bits [1:0] forced to 0.
- Taken branch: pc loads the target and taken=1 next cycle. Not taken or none: pc loads pc + PC_STEP, modulo 2^32.
- bl: link_we=1 and link_addr = old pc + PC_STEP next cycle.
- Illegal br_op: behaves as none (sequential), with illegal_op=1 next cycle.
- Priority within one advancing cycle: halt over branch. `halt=1` with a branch op does not change pc and does not pulse taken/link_we.

## Timing
- Reset (asynchronous, rst=0): pc=RESET_PC, carry_q=zero_q=sign_q=0, taken=link_we=illegal_op=0, link_addr=0, halted=0, state RUN.
- Releasing reset does not change any output until the first advancing edge.
- Latency is 1 cycle: a decision made in cycle N is visible on pc/taken/link_* after edge N.
- taken, link_we and illegal_op are high for exactly one cycle per advancing instruction. Back-to-back taken branches give back-to-back pulses.
- Reset asserted mid-operation (including mid-pulse or in HALT) clears everything immediately, without waiting for clk.
- Wrap-around: pc = 32'hFFFF_FFFC sequential becomes 32'h0000_0000. Target arithmetic wraps the same way. There is no overflow flag.

## Test plan
- Reset/sequential: rst=0 then release, RESET_PC=0, 3 advancing none-ops -> pc 0, 4, 8, 12; all pulses 0.
- Conditional with bypass: pc=0x40, flag_we=1, alu_zero=1, br_op=bz, offset=0x10 -> pc=0x54, taken=1 for one cycle, zero_q=1. The same bz next cycle with flag_we=0 and zero_q=1 is also taken.
- Not taken and carry ops: carry_q=0, bcy at pc=0x100 -> pc=0x104, taken=0. bncy with offset=-8 (0xFFFF_FFF8) at pc=0x104 -> pc=0x100.
- bl and br: bl at pc=0x20, offset=0x100 -> pc=0x124, link_we=1, link_addr=0x24. br with rs_val=0x0000_0203 -> pc=0x200.
- Stall/halt: stall=1 with b pending -> pc holds, taken=0. halt with stall=1 -> halted=1 next cycle, pc frozen for 10 cycles. rst=0 -> pc=RESET_PC, halted=0.
- Boundaries: pc=0xFFFF_FFFC none -> pc=0. br_op=12 -> pc+4, illegal_op=1 for one cycle. rst asserted mid-cycle while taken=1 -> taken=0 immediately.
